// File: rtl/host_run_ctrl.sv
// rtl/host_run_ctrl.sv - initiator side of the processor Start/Ack handshake
// Runs NUM_PROGS programs per batch and reports cycle count and timeout for each run.
`timescale 1ns/1ps
module host_run_ctrl #(
   parameter int              NUM_PROGS = 3,
   parameter int              START_LEN = 2,
   parameter int              CW        = 16,
   parameter logic [CW-1:0]   TIMEOUT   = CW'(4000)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Go,
   input  logic          Ack,
   output logic          Start,
   output logic          Busy,
   output logic          RunDone,
   output logic          TimedOut,
   output logic [CW-1:0] CycleCt,
   output logic [7:0]    ProgIdx,
   output logic          BatchDone
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_WAIT_LOW = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_REPORT   = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   // Saturating increment so a runaway run can never wrap back under TIMEOUT.
   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
   assign Busy    = (state != S_IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         Start     <= 1'b0;
         RunDone   <= 1'b0;
         TimedOut  <= 1'b0;
         CycleCt   <= '0;
         ProgIdx   <= '0;
         BatchDone <= 1'b0;
      end else begin
         RunDone <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Go) begin
                  state     <= S_START;
                  ProgIdx   <= '0;
                  BatchDone <= 1'b0;
                  cnt       <= '0;
                  Start     <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == CW'(START_LEN - 1)) begin
                  state <= S_WAIT_LOW;
                  Start <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_WAIT_LOW: begin
               // Ack still high here belongs to the previous program; wait for it to drop.
               if (!Ack) begin
                  state <= S_RUN;
                  cnt   <= '0;
               end else if (cnt_inc == TIMEOUT) begin
                  state    <= S_REPORT;
                  RunDone  <= 1'b1;
                  TimedOut <= 1'b1;
                  CycleCt  <= TIMEOUT;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_RUN: begin
               if (Ack) begin
                  state    <= S_REPORT;
                  RunDone  <= 1'b1;
                  TimedOut <= 1'b0;
                  CycleCt  <= cnt_inc;
               end else if (cnt_inc == TIMEOUT) begin
                  state    <= S_REPORT;
                  RunDone  <= 1'b1;
                  TimedOut <= 1'b1;
                  CycleCt  <= TIMEOUT;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_REPORT: begin
               if (ProgIdx == 8'(NUM_PROGS - 1)) begin
                  BatchDone <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  ProgIdx <= ProgIdx + 8'd1;
                  state   <= S_START;
                  cnt     <= '0;
                  Start   <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
